maze_cursor_driver: RTL and testbench
=====================================

Name: maze_cursor_driver

Overview:
- Drives the player's cursor through the 18x11 wire maze.
- Produces the 8-bit cell index `count` consumed by the square renderer / checkpoint logic.
- Moves one cell per 10 Hz tick from button levels and checks each move against `mazestate`.
- On hitting a wall it reports 255 (crash), holds, then respawns at the last checkpoint `begin_spot`.

Parameters:
- START_SPOT, 181, cell loaded at reset and used when `begin_spot` is invalid.
- CRASH_TICKS, 10, number of ticks `count` is held at 255 after a wall hit.
- COLS, 18, maze columns; index = row*COLS + col.
- ROWS, 11, maze rows; valid indices 0..COLS*ROWS-1 (0..197).

Ports:
- CLK  input  1  6.25 MHz system clock
- reset  input  1  synchronous, active-high reset
- tick  input  1  one-CLK-wide pulse at 10 Hz
- btnU  input  1  level, move up (row-1)
- btnD  input  1  level, move down (row+1)
- btnL  input  1  level, move left (col-1)
- btnR  input  1  level, move right (col+1)
- freeze  input  1  high while the wire-cutter stage is active; blocks movement
- mazestate  input  198  1 = open path cell, 0 = wall, bit index = cell index
- begin_spot  input  8  current checkpoint cell for respawn
- count  output  8  cursor cell index; 255 = crashed
- crash  output  1  one-CLK pulse on wall hit
- busy  output  1  high in CRASH or RESPAWN

Behaviour:
- Internal registers: row[3:0], col[4:0], state {PLAY, CRASH, RESPAWN}, tick counter, respawn divider.
- count is registered. In PLAY it equals row*18+col; in CRASH/RESPAWN it is 255.
- Reset, in any state including mid-respawn:
  - state=PLAY, row/col decoded from START_SPOT (181 -> row 10, col 1), count=181.
  - crash=0, busy=0, tick counter=0.
- PLAY, on a cycle with tick=1 and freeze=0:
  - Button priority U > D > L > R; only one direction is taken per tick.
  - Target = (row,col) adjusted by that direction.
  - Edge rules, no move and no crash: U at row 0, D at row ROWS-1, L at col 0, R at col COLS-1.
  - No button pressed: no move.
  - Target valid and mazestate[target]=1: row/col update and count shows the new index on the next CLK edge (1-cycle latency from tick).
  - Target valid and mazestate[target]=0: next cycle count=255, crash=1 for exactly one cycle, busy=1, state=CRASH, tick counter cleared. row/col are unchanged.
- freeze=1 in PLAY: ticks and buttons are ignored and count holds. freeze has no effect in CRASH/RESPAWN.
- mazestate changing while in PLAY is not rechecked for the current cell; only move targets are checked.
- CRASH:
  - Counts ticks only.
  - After CRASH_TICKS ticks (the tenth tick at default) go to RESPAWN.
  - Latch begin_spot on that transition. If the latched value is >197, substitute START_SPOT.
- RESPAWN (sequential division, no divider operator):
  - Initialise rem=latched spot, row=0.
  - Each CLK: if rem>=18 then rem-=18, row+=1; otherwise col=rem and go to PLAY.
  - Worst case 11 CLK cycles for spot 197 (row 10, col 17).
  - On the PLAY entry edge, count=row*18+col and busy=0.
  - Ticks during RESPAWN are ignored and do not queue.
- The respawn cell is not checked against mazestate.
- Button levels held across ticks produce one move per tick; there is no edge detection.

Test Plan:
- Reset, then idle 5 ticks with no buttons -> count=181, crash never asserted, busy=0.
- mazestate[163]=1, btnU held, one tick -> count=163 one CLK after tick; with btnU+btnR both held -> still 163 (U wins).
- Cursor at 180 (row 10, col 0): btnL tick -> stays 180, no crash; btnD tick -> stays 180, no crash.
- mazestate[182]=0, btnR tick from 181 -> next cycle count=255 and crash pulses 1 cycle. count holds 255 through ticks 1..9, and through the tenth tick until RESPAWN completes. With begin_spot=113 -> count=113 (row 6, col 5) within 11 CLK of tenth tick; busy drops.
- freeze=1 with btnU held for 3 ticks -> count unchanged. Deassert freeze -> next tick moves.
- begin_spot=200 at crash -> respawn to 181. Assert reset during RESPAWN -> next cycle count=181, state PLAY.

Source files
------------

// File: rtl/maze_cursor_driver.sv
// maze_cursor_driver
//   Moves the player's cursor through the COLS x ROWS wire maze, one cell per
//   tick, and produces the cell index consumed by the renderer and checkpoint
//   logic. A move into a wall shows 255 for CRASH_TICKS ticks. The cursor then
//   respawns at the last checkpoint. The checkpoint index is split into row and
//   column by repeated subtraction instead of a divider.
//
// Ports
//   CLK         system clock (6.25 MHz)
//   reset       synchronous, active-high
//   tick        one-CLK pulse at 10 Hz; paces movement and the crash hold
//   btnU/D/L/R  button levels; priority U > D > L > R, one move per tick
//   freeze      blocks movement while in PLAY
//   mazestate   1 = open cell, 0 = wall; the bit index is the cell index
//   begin_spot  respawn checkpoint; values past the last cell fall back to START_SPOT
//   count       registered cursor index; 255 while crashed or respawning
//   crash       one-CLK pulse when a move hits a wall
//   busy        high in CRASH or RESPAWN
module maze_cursor_driver #(
    parameter int START_SPOT  = 181,
    parameter int CRASH_TICKS = 10,
    parameter int COLS        = 18,
    parameter int ROWS        = 11
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 btnU,
    input  logic                 btnD,
    input  logic                 btnL,
    input  logic                 btnR,
    input  logic                 freeze,
    input  logic [COLS*ROWS-1:0] mazestate,
    input  logic [7:0]           begin_spot,
    output logic [7:0]           count,
    output logic                 crash,
    output logic                 busy
);

    localparam logic [7:0] COLS_8     = 8'(COLS);
    localparam logic [7:0] LAST_CELL  = 8'(COLS*ROWS - 1);
    localparam logic [7:0] START_8    = 8'(START_SPOT);
    localparam logic [3:0] START_ROW  = 4'(START_SPOT / COLS);
    localparam logic [4:0] START_COL  = 5'(START_SPOT % COLS);
    localparam logic [3:0] ROW_LAST   = 4'(ROWS - 1);
    localparam logic [4:0] COL_LAST   = 5'(COLS - 1);
    localparam logic [7:0] CRASH_CODE = 8'hFF;
    localparam int         TW         = $clog2(CRASH_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CRASH_TICKS - 1);

    typedef enum logic [1:0] {
        ST_PLAY    = 2'd0,
        ST_CRASH   = 2'd1,
        ST_RESPAWN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     row_q, row_d;
    logic [4:0]     col_q, col_d;
    logic [7:0]     count_q, count_d;
    logic           crash_q, crash_d;
    logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
    logic [7:0]     rem_q, rem_d;

    // Candidate move for this cycle
    logic           dir_ok;
    logic [3:0]     tgt_row;
    logic [4:0]     tgt_col;
    logic [7:0]     tgt_idx;
    logic           tgt_open;
    logic           step_en;
    logic           move_ok;
    logic           hit_wall;
    logic           crash_done;
    logic           respawn_done;
    logic [7:0]     spot_lat;

    function automatic logic [7:0] cell_idx(input logic [3:0] r, input logic [4:0] c);
        return 8'(r) * COLS_8 + 8'(c);
    endfunction

    // Highest-priority pressed button picks the direction. If that direction
    // hits the maze edge, no move is made and lower-priority buttons are not tried.
    always_comb begin
        dir_ok  = 1'b0;
        tgt_row = row_q;
        tgt_col = col_q;
        if (btnU) begin
            dir_ok  = (row_q != 4'd0);
            tgt_row = row_q - 4'd1;
        end else if (btnD) begin
            dir_ok  = (row_q != ROW_LAST);
            tgt_row = row_q + 4'd1;
        end else if (btnL) begin
            dir_ok  = (col_q != 5'd0);
            tgt_col = col_q - 5'd1;
        end else if (btnR) begin
            dir_ok  = (col_q != COL_LAST);
            tgt_col = col_q + 5'd1;
        end
    end

    assign tgt_idx  = cell_idx(tgt_row, tgt_col);
    // Range guard keeps the bit select in bounds when no real move is pending
    assign tgt_open = (tgt_idx <= LAST_CELL) && mazestate[tgt_idx];
    assign step_en  = (state_q == ST_PLAY) && tick && !freeze && dir_ok;
    assign move_ok  = step_en && tgt_open;
    assign hit_wall = step_en && !tgt_open;

    assign crash_done   = (state_q == ST_CRASH) && tick && (tick_cnt_q == TICK_LAST);
    assign respawn_done = (state_q == ST_RESPAWN) && (rem_q < COLS_8);
    assign spot_lat     = (begin_spot > LAST_CELL) ? START_8 : begin_spot;

    // State register
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= ST_PLAY;
            row_q      <= START_ROW;
            col_q      <= START_COL;
            count_q    <= START_8;
            crash_q    <= 1'b0;
            tick_cnt_q <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            count_q    <= count_d;
            crash_q    <= crash_d;
            tick_cnt_q <= tick_cnt_d;
            rem_q      <= rem_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_PLAY:    if (hit_wall)     state_d = ST_CRASH;
            ST_CRASH:   if (crash_done)   state_d = ST_RESPAWN;
            ST_RESPAWN: if (respawn_done) state_d = ST_PLAY;
            default:                      state_d = ST_PLAY;
        endcase
    end

    // Datapath updates per state
    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        count_d    = count_q;
        crash_d    = 1'b0;
        tick_cnt_d = tick_cnt_q;
        rem_d      = rem_q;
        unique case (state_q)
            ST_PLAY: begin
                if (move_ok) begin
                    row_d   = tgt_row;
                    col_d   = tgt_col;
                    count_d = tgt_idx;
                end else if (hit_wall) begin
                    // row/col stay put; they are overwritten by the respawn
                    count_d    = CRASH_CODE;
                    crash_d    = 1'b1;
                    tick_cnt_d = '0;
                end
            end
            ST_CRASH: begin
                if (crash_done) begin
                    rem_d = spot_lat;
                    row_d = 4'd0;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            ST_RESPAWN: begin
                // One row is peeled off per clock. row*COLS + rem always
                // equals the latched spot, so the final index is rebuilt from it.
                if (rem_q >= COLS_8) begin
                    rem_d = rem_q - COLS_8;
                    row_d = row_q + 4'd1;
                end else begin
                    col_d   = rem_q[4:0];
                    count_d = cell_idx(row_q, rem_q[4:0]);
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != ST_PLAY);
    end

    assign count = count_q;
    assign crash = crash_q;

endmodule

// File: tb/tb_maze_cursor_driver.sv
module tb_maze_cursor_driver;

    logic         CLK = 1'b0;
    logic         reset, tick, btnU, btnD, btnL, btnR, freeze;
    logic [197:0] mazestate;
    logic [7:0]   begin_spot;
    logic [7:0]   count;
    logic         crash, busy;

    always #80 CLK = ~CLK;

    maze_cursor_driver dut (
        .CLK        (CLK),
        .reset      (reset),
        .tick       (tick),
        .btnU       (btnU),
        .btnD       (btnD),
        .btnL       (btnL),
        .btnR       (btnR),
        .freeze     (freeze),
        .mazestate  (mazestate),
        .begin_spot (begin_spot),
        .count      (count),
        .crash      (crash),
        .busy       (busy)
    );

    typedef struct {
        int         at;
        string      nm;
        logic [7:0] cnt;
        logic       cr;
        logic       bz;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   crash_seen = 0;
    int   t;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: at each falling edge, check every expectation due for this cycle
    always @(negedge CLK) begin
        if (crash === 1'b1) crash_seen++;
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            mon_e = sbq.pop_front();
            n_cmp++;
            if (mon_e.at < cyc) begin
                n_bad++;
                $display("FAIL %s: check slot %0d missed (now %0d)", mon_e.nm, mon_e.at, cyc);
            end else if (count !== mon_e.cnt || crash !== mon_e.cr || busy !== mon_e.bz) begin
                n_bad++;
                $display("FAIL %s @%0d: got count=%0d crash=%b busy=%b, want count=%0d crash=%b busy=%b",
                         mon_e.nm, cyc, count, crash, busy, mon_e.cnt, mon_e.cr, mon_e.bz);
            end
        end
    end

    function automatic void exp_at(input int at, input string nm, input logic [7:0] c,
                                   input logic cr, input logic bz);
        exp_t e;
        e.at = at; e.nm = nm; e.cnt = c; e.cr = cr; e.bz = bz;
        sbq.push_back(e);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) step();
    endtask

    // Raise tick for exactly one sampling edge
    task automatic tick_pulse();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic mv(input logic u, input logic d, input logic l, input logic r,
                      input logic [7:0] want, input string nm);
        {btnU, btnD, btnL, btnR} = {u, d, l, r};
        tick_pulse();
        exp_at(cyc, nm, want, 1'b0, 1'b0);
        {btnU, btnD, btnL, btnR} = 4'b0000;
        gap(2);
    endtask

    // Move right into a wall, then check the one-cycle crash pulse
    task automatic hit_right(input string nm);
        btnR = 1'b1;
        tick_pulse();
        btnR = 1'b0;
        exp_at(cyc, nm, 8'd255, 1'b1, 1'b1);
        exp_at(cyc + 1, {nm, "_pulse_end"}, 8'd255, 1'b0, 1'b1);
        gap(2);
    endtask

    // Ten crash-hold ticks; returns the cycle that sampled the tenth tick
    task automatic crash_ticks(output int t10);
        for (int i = 1; i <= 9; i++) begin
            tick_pulse();
            exp_at(cyc, "crash_hold", 8'd255, 1'b0, 1'b1);
            gap(2);
        end
        tick_pulse();
        t10 = cyc;
        exp_at(t10, "tenth_tick", 8'd255, 1'b0, 1'b1);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        repeat (20000) @(posedge CLK);
        n_bad++;
        $display("FAIL watchdog: cycle limit reached, bench did not finish");
        summary();
        $finish;
    end

    initial begin
        reset = 1'b1; tick = 1'b0; freeze = 1'b0;
        {btnU, btnD, btnL, btnR} = 4'b0000;
        mazestate = '1;
        mazestate[182] = 1'b0;
        begin_spot = 8'd113;
        gap(3);
        exp_at(cyc, "reset", 8'd181, 1'b0, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tick_pulse();
            exp_at(cyc, "idle", 8'd181, 1'b0, 1'b0);
            gap(2);
        end

        mv(1, 0, 0, 0, 8'd163, "up");
        mv(0, 1, 0, 0, 8'd181, "down");
        mv(1, 0, 0, 1, 8'd163, "u_beats_r");   // R would hit the wall at 182
        mv(0, 1, 0, 0, 8'd181, "down2");
        mv(0, 0, 1, 0, 8'd180, "left");
        mv(0, 0, 1, 0, 8'd180, "left_edge");
        mv(0, 1, 0, 0, 8'd180, "down_edge");
        mv(0, 0, 0, 1, 8'd181, "right");

        // Crash, then respawn at 113: six subtractions, then PLAY on the 7th clock
        hit_right("crash1");
        crash_ticks(t);
        exp_at(t + 6, "respawn_busy", 8'd255, 1'b0, 1'b1);
        exp_at(t + 7, "respawn_113", 8'd113, 1'b0, 1'b0);
        btnU = 1'b1;
        tick_pulse();                           // lands in RESPAWN, must not queue
        btnU = 1'b0;
        exp_at(t + 9, "no_queued_tick", 8'd113, 1'b0, 1'b0);
        gap(10);

        freeze = 1'b1;
        btnU = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_pulse();
            exp_at(cyc, "frozen", 8'd113, 1'b0, 1'b0);
            gap(2);
        end
        freeze = 1'b0;
        tick_pulse();
        exp_at(cyc, "thaw_move", 8'd95, 1'b0, 1'b0);
        btnU = 1'b0;
        gap(2);

        // Invalid checkpoint falls back to 181: ten subtractions + 1
        mazestate[96] = 1'b0;
        begin_spot = 8'd200;
        hit_right("crash2");
        crash_ticks(t);
        exp_at(t + 10, "respawn_busy2", 8'd255, 1'b0, 1'b1);
        exp_at(t + 11, "respawn_bad_spot", 8'd181, 1'b0, 1'b0);
        gap(13);

        // Reset in the middle of a respawn
        begin_spot = 8'd113;
        hit_right("crash3");
        crash_ticks(t);
        gap(2);
        reset = 1'b1;
        step();
        exp_at(cyc, "reset_mid_respawn", 8'd181, 1'b0, 1'b0);
        reset = 1'b0;
        gap(2);
        tick_pulse();
        exp_at(cyc, "after_reset_idle", 8'd181, 1'b0, 1'b0);
        gap(3);

        n_cmp++;
        if (crash_seen != 3) begin
            n_bad++;
            $display("FAIL crash_pulse_count: got %0d, want 3", crash_seen);
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d unchecked, want 0", sbq.size());
        end
        summary();
        $finish;
    end

endmodule
